// File: rtl/hook_swing_ctrl_if.sv
// Bundles the hook_swing_ctrl control inputs and draw/status outputs.
// No timing of its own; every signal is a plain wire between sequencer and environment.
// No backpressure: draw_en/draw_done and fire/hook_back are single-cycle pulses.
// Optional: HOOK_SWING_SWEEPCNT_EN adds the 8-bit sweep_count output.
// Ports: master = sequencer (drives degree/draw_en/status), slave = environment.
interface hook_swing_ctrl_if;
    logic       run;
    logic       fire;
    logic       hook_back;
    logic       draw_done;
    logic [8:0] degree;
    logic       draw_en;
    logic       swinging;
    logic       fire_ack;
    logic       timeout_err;
`ifdef HOOK_SWING_SWEEPCNT_EN
    logic [7:0] sweep_count;

    modport master (
        input  run, fire, hook_back, draw_done,
        output degree, draw_en, swinging, fire_ack, timeout_err, sweep_count
    );
    modport slave (
        output run, fire, hook_back, draw_done,
        input  degree, draw_en, swinging, fire_ack, timeout_err, sweep_count
    );
`else
    modport master (
        input  run, fire, hook_back, draw_done,
        output degree, draw_en, swinging, fire_ack, timeout_err
    );
    modport slave (
        output run, fire, hook_back, draw_done,
        input  degree, draw_en, swinging, fire_ack, timeout_err
    );
`endif
endinterface

// File: rtl/hook_swing_ctrl.sv
// Hook angle sequencer: sweeps degree between MIN_DEG/MAX_DEG one STEP per tick, requests a draw after each change.
// Latency: draw_en one cycle after run rises or hook_back; new angle is visible in the draw_en cycle.
// Backpressure: waits for draw_done (bounded by DONE_TIMEOUT) before advancing; fire freezes the angle until hook_back.
// Ports: clock, resetn (async active-low); hif (master): run/fire/hook_back/draw_done in,
//        degree/draw_en/swinging/fire_ack/timeout_err out.
// Optional: define HOOK_SWING_SWEEPCNT_EN to add hif.sweep_count, counting direction flips.
module hook_swing_ctrl #(
    parameter int MIN_DEG      = 20,
    parameter int MAX_DEG      = 160,
    parameter int START_DEG    = 90,
    parameter int STEP         = 2,
    parameter int TICK_CYCLES  = 833334,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              resetn,
    hook_swing_ctrl_if.master hif
);
    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int TO_W   = $clog2(DONE_TIMEOUT + 1);
    localparam logic [9:0] MIN10  = 10'(MIN_DEG);
    localparam logic [9:0] MAX10  = 10'(MAX_DEG);
    localparam logic [9:0] STEP10 = 10'(STEP);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_TICK, HOLD} state_t;

    state_t            state_q, state_d;
    logic [8:0]        degree_q, degree_d;
    logic              dir_up_q, dir_up_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fire_pending_q, fire_pending_d;
    logic              fire_ack_q, fire_ack_d;
    logic              timeout_err_q, timeout_err_d;
`ifdef HOOK_SWING_SWEEPCNT_EN
    logic [7:0]        sweep_cnt_q, sweep_cnt_d;
`endif

    logic [9:0] deg_ext;
    logic [8:0] nxt_deg;
    logic       nxt_dir_up;
    logic       tick_expired;
    logic       to_expired;

    // Candidate angle for the next tick; 10-bit so the limit compares cannot wrap.
    always_comb begin
        deg_ext    = {1'b0, degree_q};
        nxt_deg    = degree_q;
        nxt_dir_up = dir_up_q;
        if (dir_up_q) begin
            if (deg_ext + STEP10 >= MAX10) begin
                nxt_deg    = MAX10[8:0];
                nxt_dir_up = 1'b0;
            end else begin
                nxt_deg = 9'(deg_ext + STEP10);
            end
        end else begin
            if (deg_ext <= MIN10 + STEP10) begin
                nxt_deg    = MIN10[8:0];
                nxt_dir_up = 1'b1;
            end else begin
                nxt_deg = 9'(deg_ext - STEP10);
            end
        end
    end

    // Expiry is judged on the incremented count, so WAIT_DONE gives up in the
    // cycle its count would reach DONE_TIMEOUT-1 (error flag lands DONE_TIMEOUT cycles after draw_en).
    assign tick_expired = (int'(tick_cnt_q) + 1) >= (TICK_CYCLES - 1);
    assign to_expired   = (int'(to_cnt_q) + 1) >= (DONE_TIMEOUT - 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            degree_q       <= 9'(START_DEG);
            dir_up_q       <= 1'b1;
            tick_cnt_q     <= '0;
            to_cnt_q       <= '0;
            fire_pending_q <= 1'b0;
            fire_ack_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
`ifdef HOOK_SWING_SWEEPCNT_EN
            sweep_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            degree_q       <= degree_d;
            dir_up_q       <= dir_up_d;
            tick_cnt_q     <= tick_cnt_d;
            to_cnt_q       <= to_cnt_d;
            fire_pending_q <= fire_pending_d;
            fire_ack_q     <= fire_ack_d;
            timeout_err_q  <= timeout_err_d;
`ifdef HOOK_SWING_SWEEPCNT_EN
            sweep_cnt_q    <= sweep_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        degree_d       = degree_q;
        dir_up_d       = dir_up_q;
        tick_cnt_d     = tick_cnt_q;
        to_cnt_d       = to_cnt_q;
        fire_pending_d = fire_pending_q;
        fire_ack_d     = 1'b0;
        timeout_err_d  = timeout_err_q;
`ifdef HOOK_SWING_SWEEPCNT_EN
        sweep_cnt_d    = sweep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // A fire latched before run dropped must not freeze the next session.
                fire_pending_d = 1'b0;
                if (hif.run) state_d = ISSUE;
            end
            ISSUE: begin
                to_cnt_d = '0;
                if (hif.fire) fire_pending_d = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (hif.fire) fire_pending_d = 1'b1;
                if (hif.draw_done || to_expired) begin
                    if (!hif.draw_done) timeout_err_d = 1'b1;
                    if (!hif.run) begin
                        state_d        = IDLE;
                        fire_pending_d = 1'b0;
                    end else if (fire_pending_q) begin
                        state_d        = HOLD;
                        fire_ack_d     = 1'b1;
                        fire_pending_d = 1'b0;
                    end else begin
                        // A fire arriving in this very cycle stays pending and is taken from WAIT_TICK.
                        state_d    = WAIT_TICK;
                        tick_cnt_d = '0;
                    end
                end
            end
            WAIT_TICK: begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
                if (!hif.run) begin
                    state_d = IDLE;
                end else if (hif.fire || fire_pending_q) begin
                    state_d        = HOLD;
                    fire_ack_d     = 1'b1;
                    fire_pending_d = 1'b0;
                end else if (tick_expired) begin
                    state_d  = ISSUE;
                    degree_d = nxt_deg;
                    dir_up_d = nxt_dir_up;
`ifdef HOOK_SWING_SWEEPCNT_EN
                    if (nxt_dir_up != dir_up_q) sweep_cnt_d = sweep_cnt_q + 8'd1;
`endif
                end
            end
            HOLD: begin
                if (!hif.run)          state_d = IDLE;
                else if (hif.hook_back) state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hif.degree      = degree_q;
    assign hif.draw_en     = (state_q == ISSUE);
    assign hif.swinging    = (state_q == ISSUE) || (state_q == WAIT_DONE) || (state_q == WAIT_TICK);
    assign hif.fire_ack    = fire_ack_q;
    assign hif.timeout_err = timeout_err_q;
`ifdef HOOK_SWING_SWEEPCNT_EN
    assign hif.sweep_count = sweep_cnt_q;
`endif
endmodule

// File: doc/hook_swing_ctrl.md
Name: hook_swing_ctrl

Overview:
Upstream sequencer for the hook renderer. It owns the hook angle and sweeps it back and forth between two limits, one step per frame tick. After each angle change it issues a one-cycle draw request to the hook drawing FSM and waits for that FSM's done pulse. When the player fires, it freezes the angle until the hook returns.

Parameters:
MIN_DEG, 20, lower swing limit in degrees (0..359)
MAX_DEG, 160, upper swing limit in degrees (MIN_DEG < MAX_DEG <= 359)
START_DEG, 90, angle loaded at reset (MIN_DEG..MAX_DEG)
STEP, 2, degrees moved per tick (1..MAX_DEG-MIN_DEG)
TICK_CYCLES, 833334, clock cycles between angle updates (>= 2)
DONE_TIMEOUT, 1024, maximum cycles to wait for draw_done before giving up

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  reset; asynchronous, active-low
run  in  1  level; high = block active
fire  in  1  single-cycle pulse; player launches hook
hook_back  in  1  single-cycle pulse; hook has retracted
draw_done  in  1  single-cycle done pulse from the hook drawing FSM
degree  out  9  current hook angle, registered, stable while a draw is in flight
draw_en  out  1  one-cycle request to the hook drawing FSM
swinging  out  1  high while the angle is allowed to advance (not HOLD, not IDLE)
fire_ack  out  1  one-cycle pulse on entry to HOLD
timeout_err  out  1  sticky flag; set on draw_done timeout

Behaviour:
- Reset (resetn low, asynchronous):
  - State = IDLE; degree = START_DEG; direction = up.
  - Tick counter, timeout counter and fire_pending = 0.
  - draw_en, swinging, fire_ack and timeout_err = 0.
  - Reset mid-draw abandons the draw. No further draw_en is issued until run is high again.
- States: IDLE, ISSUE, WAIT_DONE, WAIT_TICK, HOLD.
- IDLE: if run = 1, go to ISSUE next cycle. This draws the current angle with no tick wait.
- ISSUE: draw_en = 1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE: increment the timeout counter each cycle.
  - draw_done = 1: exit.
  - Timeout counter reaches DONE_TIMEOUT-1 with no draw_done: set timeout_err, then exit the same way.
  - Exit priority: run = 0 -> IDLE; else fire_pending = 1 -> HOLD (pulse fire_ack, clear fire_pending); else -> WAIT_TICK with the tick counter cleared.
  - draw_done in any state other than WAIT_DONE is ignored.
- WAIT_TICK: increment the tick counter.
  - run = 0: go to IDLE immediately.
  - fire or fire_pending: go to HOLD and pulse fire_ack.
  - Tick counter reaches TICK_CYCLES-1: update the angle and go to ISSUE. The new degree is visible in the ISSUE cycle.
- Angle update, direction up:
  - If degree + STEP >= MAX_DEG: degree = MAX_DEG and direction flips to down.
  - Else degree += STEP.
- Angle update, direction down:
  - If degree <= MIN_DEG + STEP: degree = MIN_DEG and direction flips to up.
  - Else degree -= STEP.
  - Comparisons use 10-bit arithmetic, so there is no underflow or overflow.
- HOLD:
  - degree is frozen and swinging = 0; fire is ignored.
  - hook_back = 1: go to ISSUE (redraw at the held angle); direction is kept.
  - run = 0: go to IDLE.
  - run = 0 and hook_back in the same cycle: IDLE wins.
- Fire handling:
  - fire during ISSUE or WAIT_DONE sets fire_pending; it is honoured at WAIT_DONE exit.
  - fire in IDLE is dropped.
- swinging = 1 in ISSUE, WAIT_DONE and WAIT_TICK; 0 otherwise.
- timeout_err is cleared only by reset.

Optional Feature:
HOOK_SWING_SWEEPCNT_EN
- Defined: adds output sweep_count (8 bits), reset to 0.
  - Increments by 1 on every direction flip.
  - Wraps 255 -> 0.
  - Frozen in HOLD and IDLE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. TICK_CYCLES=4, draw_done returned 3 cycles after each draw_en; raise run -> draw_en with degree=90, then draw_en on successive ticks with degree 92, 94, 96; draw_en is never high for more than one cycle.
2. START_DEG=158, STEP=2 -> angle sequence 158, 160, 158, 156 (saturate and flip at MAX). Second case, START_DEG=21, direction forced down -> 21, 20, 22 (clamp at MIN, flip up).
3. Pulse fire while in WAIT_DONE at degree=100 -> after draw_done, fire_ack pulses and swinging=0; degree stays 100 for 50 cycles. Pulse hook_back -> draw_en next cycle with degree=100, then the next tick gives 102.
4. DONE_TIMEOUT=8, draw_done never returned -> timeout_err=1 exactly 8 cycles after draw_en; the block proceeds to WAIT_TICK; timeout_err stays 1 until reset.
5. Drop run in WAIT_TICK -> IDLE the next cycle with degree held. Assert resetn=0 asynchronously mid-WAIT_DONE -> all outputs 0 and degree=START_DEG without waiting for a clock edge.
6. With HOOK_SWING_SWEEPCNT_EN defined, MIN_DEG=20, MAX_DEG=24, STEP=2 -> sweep_count increments at each limit and reads 0 again after the 256th flip.
